tbuart_xcvr: RTL and testbench
==============================

// Module: tbuart_xcvr
// PURPOSE
// - Full-duplex 8N1 UART transceiver modelling an off-chip terminal attached to the SoC user GPIO pins.
// - The transmitter drives the chip's UART RX pin; the receiver listens on the chip's UART TX pin.
// - A bench loads a byte and holds a start request.
//   The block serialises the byte LSB-first and reports busy/done through a clear-request handshake.
// - Received bytes are presented as single-cycle strobes.
// PARAMETERS
// - CLKS_PER_BIT  default 4167  clock cycles per bit period (40 MHz / 9600 baud); legal range >= 4.
// PORTS
// - clock         in   1  single system clock; all logic is rising-edge.
// - reset         in   1  synchronous, active-high reset.
// - ser_rx        in   1  serial input, idle high; asynchronous to clock.
// - ser_tx        out  1  serial output, idle high.
// - tx_start      in   1  level request to send tx_data.
// - tx_data       in   8  byte to send; sampled only in the cycle the frame starts.
// - tx_busy       out  1  high while a frame is being shifted out.
// - tx_clear_req  out  1  high after a frame completes, until tx_start is seen low.
// - rx_data       out  8  last received byte; holds its value between frames.
// - rx_valid      out  1  one-cycle strobe: rx_data has been updated.
// - rx_ferr       out  1  one-cycle strobe: stop bit was sampled low; the byte is discarded.
// BEHAVIOUR
// - Reset values: ser_tx=1, tx_busy=0, tx_clear_req=0, rx_data=0, rx_valid=0, rx_ferr=0.
//   Both FSMs return to IDLE and all counters clear.
// - TX FSM states: IDLE -> START -> DATA(8 bits) -> STOP -> DONE -> IDLE.
//   - IDLE: when tx_start=1 and tx_clear_req=0, latch tx_data.
//     ser_tx goes 0 and tx_busy goes 1 on the next rising edge (latency 1 cycle).
//   - Each bit is held for exactly CLKS_PER_BIT cycles; data is sent LSB first; the stop bit is 1.
//   - At the end of the stop bit: tx_busy->0, tx_clear_req->1, enter DONE.
//   - DONE: stay until tx_start=0, then clear tx_clear_req and return to IDLE.
//     Holding tx_start high therefore never re-sends a byte.
//   - Changes on tx_start or tx_data mid-frame are ignored.
// - RX path:
//   - ser_rx passes through a 2-flop synchroniser.
//   - RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: a 1->0 transition on the synchronised line starts a half-bit count.
//   - START: at the half-bit point the line is resampled. If high, the start is false: return to IDLE with no strobe.
//   - DATA: 8 samples taken at CLKS_PER_BIT intervals (mid-bit), shifted in LSB first.
//   - STOP: mid-bit sample. If 1, load rx_data and pulse rx_valid; if 0, pulse rx_ferr.
//   - IDLE is re-entered right after the stop sample, so back-to-back frames are accepted.
// - TX and RX are fully independent. A simultaneous TX and RX frame, including loopback ser_tx->ser_rx, must work.
// - Reset asserted mid-frame aborts both FSMs: ser_tx returns to 1 on the next edge and no strobe is produced.
// - Counters are wide enough for CLKS_PER_BIT-1 with no wrap.
// CONFIGURATION
// - UART_PARITY_EN defined: an even-parity bit is inserted after bit 7 on TX (frame is 11 bits, 8E1).
//   - RX expects a parity bit before the stop bit.
//   - On parity mismatch, rx_ferr pulses instead of rx_valid.
// - UART_PARITY_EN undefined: plain 8N1, 10-bit frames, no parity logic.
// TESTING (CLKS_PER_BIT=16 unless stated)
// - Reset: hold reset 3 cycles -> ser_tx=1, tx_busy=0, tx_clear_req=0, rx_valid=0.
// - TX 0x3D with tx_start held high:
//   - ser_tx = 0,1,0,1,1,1,1,0,0,1, each bit 16 cycles.
//   - tx_busy is high 160 cycles, then tx_clear_req=1.
//   - Lower tx_start -> tx_clear_req=0 one cycle later; no second frame is sent.
// - RX: drive a 0x0F frame on ser_rx -> one rx_valid pulse with rx_data=0x0F.
//   A stop bit driven 0 -> rx_ferr pulse, rx_data unchanged.
// - False start: a 5-cycle low glitch on ser_rx -> no strobe; the FSM is idle at the next bit time.
// - Loopback ser_tx->ser_rx: send 0x00, 0xFF, 0xA5 back-to-back -> three rx_valid pulses carrying the same values.
// - Reset at bit 4 of a TX frame -> ser_tx=1 next cycle, tx_busy=0.
//   With UART_PARITY_EN, 0x3D sends parity bit 1.

Source files
------------

// File: rtl/tbuart_xcvr.sv
// Full-duplex UART transceiver modelling an off-chip terminal on the SoC GPIO pins.
// Default build is 8N1; define UART_PARITY_EN for 8E1 frames with RX parity checking.
module tbuart_xcvr #(
    parameter int CLKS_PER_BIT = 4167
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ser_rx,
    output logic       ser_tx,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_clear_req,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP, TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    tx_state_t       tx_state, tx_state_n;
    logic [CW-1:0]   tx_cnt, tx_cnt_n;
    logic [2:0]      tx_idx, tx_idx_n;
    logic [7:0]      tx_shift, tx_shift_n;
    logic            ser_tx_n, tx_busy_n, tx_clear_req_n;
`ifdef UART_PARITY_EN
    logic            tx_par, tx_par_n;
`endif

    rx_state_t       rx_state, rx_state_n;
    logic [CW-1:0]   rx_cnt, rx_cnt_n;
    logic [2:0]      rx_idx, rx_idx_n;
    logic [7:0]      rx_shift, rx_shift_n;
    logic [7:0]      rx_data_n;
    logic            rx_valid_n, rx_ferr_n;
    logic            rx_meta, rx_sync, rx_prev;
`ifdef UART_PARITY_EN
    logic            rx_perr, rx_perr_n;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state     <= TX_IDLE;
            tx_cnt       <= '0;
            tx_idx       <= '0;
            tx_shift     <= '0;
            ser_tx       <= 1'b1;
            tx_busy      <= 1'b0;
            tx_clear_req <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par       <= 1'b0;
`endif
        end else begin
            tx_state     <= tx_state_n;
            tx_cnt       <= tx_cnt_n;
            tx_idx       <= tx_idx_n;
            tx_shift     <= tx_shift_n;
            ser_tx       <= ser_tx_n;
            tx_busy      <= tx_busy_n;
            tx_clear_req <= tx_clear_req_n;
`ifdef UART_PARITY_EN
            tx_par       <= tx_par_n;
`endif
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the FSM.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
`ifdef UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        case (tx_state)
            TX_IDLE: begin
                if (tx_start && !tx_clear_req) begin
                    tx_state_n = TX_START;
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_data;
`ifdef UART_PARITY_EN
                    tx_par_n   = ^tx_data;
`endif
                end
            end
            TX_START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_state_n = TX_PARITY;
`else
                        tx_state_n = TX_STOP;
`endif
                    end else begin
                        tx_idx_n = tx_idx + 3'd1;
                    end
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
`endif
            TX_STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = TX_DONE;
                    tx_cnt_n   = '0;
                end else begin
                    tx_cnt_n = tx_cnt + CW'(1);
                end
            end
            TX_DONE: begin
                if (!tx_start) begin
                    tx_state_n = TX_IDLE;
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase

        case (tx_state_n)
            TX_START:  ser_tx_n = 1'b0;
            TX_DATA:   ser_tx_n = tx_shift_n[0];
`ifdef UART_PARITY_EN
            TX_PARITY: ser_tx_n = tx_par_n;
`endif
            default:   ser_tx_n = 1'b1;
        endcase
        tx_busy_n      = (tx_state_n == TX_START) || (tx_state_n == TX_DATA) ||
                         (tx_state_n == TX_PARITY) || (tx_state_n == TX_STOP);
        tx_clear_req_n = (tx_state_n == TX_DONE);
    end

    // The serial input is asynchronous, so it is synchronised before any use.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_prev  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_perr  <= 1'b0;
`endif
        end else begin
            rx_meta  <= ser_rx;
            rx_sync  <= rx_meta;
            rx_prev  <= rx_sync;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_data  <= rx_data_n;
            rx_valid <= rx_valid_n;
            rx_ferr  <= rx_ferr_n;
`ifdef UART_PARITY_EN
            rx_perr  <= rx_perr_n;
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_data_n  = rx_data;
        rx_valid_n = 1'b0;
        rx_ferr_n  = 1'b0;
`ifdef UART_PARITY_EN
        rx_perr_n  = rx_perr;
`endif
        case (rx_state)
            RX_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    rx_state_n = RX_START;
                    rx_cnt_n   = '0;
                end
            end
            // A start bit that is gone by mid-bit was a glitch.
            RX_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n = '0;
                    rx_idx_n = '0;
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        rx_state_n = RX_PARITY;
`else
                        rx_state_n = RX_STOP;
`endif
                    end else begin
                        rx_idx_n = rx_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_perr_n  = rx_sync ^ (^rx_shift);
                    rx_state_n = RX_STOP;
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
`endif
            RX_STOP: begin
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
`ifdef UART_PARITY_EN
                    if (rx_sync && !rx_perr) begin
`else
                    if (rx_sync) begin
`endif
                        rx_data_n  = rx_shift;
                        rx_valid_n = 1'b1;
                    end else begin
                        rx_ferr_n = 1'b1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt + CW'(1);
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tbuart_xcvr.sv
// Directed bench for tbuart_xcvr at 16 clocks per bit: TX framing and handshake,
// RX strobes, framing error, false start, loopback and mid-frame reset.
module tb_tbuart_xcvr;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       ser_tx;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       tx_clear_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ferr;
    logic       rxDrive;
    logic       loopback;
    logic       serRxLine;

    int vectorCount = 0;
    int missCount   = 0;
    int validCount  = 0;
    int ferrCount   = 0;
    logic [7:0] rxLog [16];

    assign serRxLine = loopback ? ser_tx : rxDrive;

    tbuart_xcvr #(.CLKS_PER_BIT(CPB)) dut (
        .clock        (clock),
        .reset        (reset),
        .ser_rx       (serRxLine),
        .ser_tx       (ser_tx),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_busy      (tx_busy),
        .tx_clear_req (tx_clear_req),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ferr      (rx_ferr)
    );

    always #5 clock = ~clock;

    // Every cycle a strobe is high is counted, so a stretched strobe shows up as an extra pulse.
    always @(negedge clock) begin
        if (rx_valid) begin
            if (validCount < 16) rxLog[validCount] = rx_data;
            validCount++;
        end
        if (rx_ferr) ferrCount++;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one serial frame on the RX line, bit by bit, starting at a falling clock edge.
    task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
        rxDrive = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rxDrive = value[i];
            repeat (CPB) @(negedge clock);
        end
        rxDrive = stopBit;
        repeat (CPB) @(negedge clock);
        rxDrive = 1'b1;
        repeat (4) @(negedge clock);
    endtask

    task automatic sendByte(input logic [7:0] value);
        int waited;
        tx_data  = value;
        tx_start = 1'b1;
        waited   = 0;
        while (!tx_clear_req && waited < 400) begin
            @(negedge clock);
            waited++;
        end
        checkOutput("tx_done_in_time", 32'(tx_clear_req), 32'd1);
        tx_start = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        logic [9:0] frame3d;
        int busyCycles;
        int highCycles;
        int baseValid;

        reset    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        rxDrive  = 1'b1;
        loopback = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_ser_tx",   32'(ser_tx),       32'd1);
        checkOutput("reset_busy",     32'(tx_busy),      32'd0);
        checkOutput("reset_clear",    32'(tx_clear_req), 32'd0);
        checkOutput("reset_rx_valid", 32'(rx_valid),     32'd0);
        checkOutput("reset_rx_ferr",  32'(rx_ferr),      32'd0);
        checkOutput("reset_rx_data",  32'(rx_data),      32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 0x3D as start, LSB-first data, stop: 0,1,0,1,1,1,1,0,0,1
        frame3d    = 10'b1001111010;
        busyCycles = 0;
        tx_data    = 8'h3D;
        tx_start   = 1'b1;
        for (int i = 1; i <= 170; i++) begin
            @(negedge clock);
            if (i == 50) tx_data = 8'hFF;
            if (tx_busy) busyCycles++;
            if (i == 1) checkOutput("tx_start_latency", 32'(ser_tx), 32'd0);
            for (int k = 0; k < 10; k++)
                if (i == 9 + CPB * k) checkOutput($sformatf("tx3d_bit%0d", k),
                                                  32'(ser_tx), 32'(frame3d[k]));
            if (i == 160) checkOutput("tx_busy_last", 32'(tx_busy), 32'd1);
            if (i == 161) begin
                checkOutput("tx_busy_drop",  32'(tx_busy),      32'd0);
                checkOutput("tx_clear_set",  32'(tx_clear_req), 32'd1);
            end
        end
        checkOutput("tx_busy_cycles", 32'(busyCycles), 32'd160);
        checkOutput("tx_clear_held",  32'(tx_clear_req), 32'd1);
        tx_start = 1'b0;
        @(negedge clock);
        checkOutput("tx_clear_drop", 32'(tx_clear_req), 32'd0);
        highCycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (ser_tx && !tx_busy) highCycles++;
        end
        checkOutput("tx_no_resend", 32'(highCycles), 32'd40);
        checkOutput("rx_quiet_during_tx", 32'(validCount + ferrCount), 32'd0);

        applyStimulus(8'h0F, 1'b1);
        checkOutput("rx0f_pulses", 32'(validCount), 32'd1);
        checkOutput("rx0f_data",   32'(rxLog[0]),   32'h0F);
        checkOutput("rx0f_hold",   32'(rx_data),    32'h0F);
        checkOutput("rx0f_ferr",   32'(ferrCount),  32'd0);

        applyStimulus(8'hA0, 1'b0);
        checkOutput("ferr_pulses", 32'(ferrCount),  32'd1);
        checkOutput("ferr_valid",  32'(validCount), 32'd1);
        checkOutput("ferr_data",   32'(rx_data),    32'h0F);

        rxDrive = 1'b0;
        repeat (5) @(negedge clock);
        rxDrive = 1'b1;
        repeat (CPB + 4) @(negedge clock);
        checkOutput("glitch_no_strobe", 32'(validCount + ferrCount), 32'd2);
        applyStimulus(8'h55, 1'b1);
        checkOutput("after_glitch_pulses", 32'(validCount), 32'd2);
        checkOutput("after_glitch_data",   32'(rxLog[1]),   32'h55);

        loopback  = 1'b1;
        baseValid = validCount;
        sendByte(8'h00);
        sendByte(8'hFF);
        sendByte(8'hA5);
        repeat (30) @(negedge clock);
        checkOutput("loop_pulses", 32'(validCount - baseValid), 32'd3);
        checkOutput("loop_byte0",  32'(rxLog[2]), 32'h00);
        checkOutput("loop_byte1",  32'(rxLog[3]), 32'hFF);
        checkOutput("loop_byte2",  32'(rxLog[4]), 32'hA5);
        checkOutput("loop_ferr",   32'(ferrCount), 32'd1);

        // 0x0F has bit 4 low, so the return of ser_tx to idle is visible.
        loopback = 1'b0;
        repeat (5) @(negedge clock);
        tx_data  = 8'h0F;
        tx_start = 1'b1;
        repeat (1 + CPB * 5 + 8) @(negedge clock);
        checkOutput("midreset_bit4", 32'(ser_tx),  32'd0);
        checkOutput("midreset_busy", 32'(tx_busy), 32'd1);
        reset    = 1'b1;
        tx_start = 1'b0;
        @(negedge clock);
        checkOutput("midreset_ser_tx",  32'(ser_tx),       32'd1);
        checkOutput("midreset_busy0",   32'(tx_busy),      32'd0);
        checkOutput("midreset_clear",   32'(tx_clear_req), 32'd0);
        checkOutput("midreset_rx_data", 32'(rx_data),      32'd0);
        reset = 1'b0;
        repeat (CPB * 3) @(negedge clock);
        checkOutput("midreset_idle", 32'(ser_tx), 32'd1);
        checkOutput("midreset_no_strobe", 32'(validCount), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
